sync_fifo: RTL and testbench

Synchronous single-clock FIFO with valid/ready handshakes on both sides and first-word-fall-through output. It is the per-input-port flit buffer of the NoC router cell, with one instance on each of the five directional ports (N, E, S, W, L). It also serves as a generic elastic buffer elsewhere in the fabric.

---
 rtl/sync_fifo_pkg.sv | 9 +
 rtl/sync_fifo.sv | 89 ++++++++
 tb/tb_sync_fifo.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the synchronous FIFO.
// Pointer wrap is computed on integers so non-power-of-two depths never rely on overflow.
package sync_fifo_pkg;

  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
// Define FIFO_CHECK_EN to compile simulation-only consistency checks.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wp_q, wp_d;
  logic [PtrW-1:0]  rp_q, rp_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop;

  // Full blocks a push even when a pop happens, so din_ready never depends on dout_ready.
  assign din_ready  = (count_q != CntW'(DEPTH));
  assign dout_valid = (count_q != '0);
  assign dout       = dout_valid ? mem[rp_q] : '0;

  assign push = din_valid && din_ready;
  assign pop  = dout_valid && dout_ready;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (push) wp_d = PtrW'(wrap_inc(32'(wp_q), DEPTH));
    if (pop)  rp_d = PtrW'(wrap_inc(32'(rp_q), DEPTH));
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= din;
  end

`ifdef FIFO_CHECK_EN
  logic [WIDTH-1:0] chk_dout_q;
  logic             chk_hold_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_hold_q <= 1'b0;
    end else begin
      if (count_q > CntW'(DEPTH)) $error("%m: count %0d exceeds depth", count_q);
      if (wp_q == rp_q) begin
        if (count_q != '0 && count_q != CntW'(DEPTH))
          $error("%m: count %0d with equal pointers", count_q);
      end else if (int'(count_q) !=
                   (int'(wp_q) - int'(rp_q) + int'(DEPTH)) % int'(DEPTH)) begin
        $error("%m: count %0d inconsistent with pointers", count_q);
      end
      if (chk_hold_q && dout != chk_dout_q) $error("%m: head changed while stalled");
      chk_hold_q <= dout_valid && !dout_ready;
    end
    chk_dout_q <= dout;
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: two depths driven in lockstep, each checked against a queue model.
module tb_sync_fifo;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         dout_ready;

  logic         din_ready_a, dout_valid_a;
  logic [W-1:0] dout_a;
  logic         din_ready_b, dout_valid_b;
  logic [W-1:0] dout_b;

  logic [W-1:0] q_a [$];
  logic [W-1:0] q_b [$];

  int checks = 0;
  int errors = 0;

  sync_fifo #(.WIDTH(W), .DEPTH(4)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready_a),
    .dout       (dout_a),
    .dout_valid (dout_valid_a),
    .dout_ready (dout_ready)
  );

  sync_fifo #(.WIDTH(W), .DEPTH(3)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready_b),
    .dout       (dout_b),
    .dout_valid (dout_valid_b),
    .dout_ready (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("a_ready", 64'(din_ready_a), 64'(q_a.size() != 4));
    check("a_valid", 64'(dout_valid_a), 64'(q_a.size() != 0));
    check("a_dout", 64'(dout_a), (q_a.size() != 0) ? 64'(q_a[0]) : 64'd0);
    check("b_ready", 64'(din_ready_b), 64'(q_b.size() != 3));
    check("b_valid", 64'(dout_valid_b), 64'(q_b.size() != 0));
    check("b_dout", 64'(dout_b), (q_b.size() != 0) ? 64'(q_b[0]) : 64'd0);
  endtask

  // Drives one cycle's inputs, checks outputs mid-cycle, then applies the edge to the models.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
    bit ok_a, ok_b, has_a, has_b;
    din_valid  = v;
    din        = d;
    dout_ready = r;
    #1;
    check_model();
    ok_a  = q_a.size() < 4;
    ok_b  = q_b.size() < 3;
    has_a = q_a.size() > 0;
    has_b = q_b.size() > 0;
    @(posedge clk);
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (r && has_a) void'(q_a.pop_front());
      if (r && has_b) void'(q_b.pop_front());
      if (v && ok_a) q_a.push_back(d);
      if (v && ok_b) q_b.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset, then first-word fall-through of 0xA5.
    check("rst_ready", 64'(din_ready_a), 64'd1);
    check("rst_valid", 64'(dout_valid_a), 64'd0);
    check("rst_dout", 64'(dout_a), 64'd0);
    cycle(1'b1, 16'h00A5, 1'b0);
    check("a5_valid", 64'(dout_valid_a), 64'd1);
    check("a5_dout", 64'(dout_a), 64'h00A5);
    cycle(1'b0, 16'h0000, 1'b1);

    // Fill to full; extra offers are refused, also when a pop lands in the same cycle.
    for (int i = 1; i <= 4; i++) cycle(1'b1, W'(i), 1'b0);
    check("full_ready", 64'(din_ready_a), 64'd0);
    cycle(1'b1, 16'd5, 1'b0);
    check("full_head", 64'(dout_a), 64'd1);
    cycle(1'b1, 16'd5, 1'b1);
    check("popfull_ready", 64'(din_ready_a), 64'd1);
    check("popfull_head", 64'(dout_a), 64'd2);
    cycle(1'b1, 16'd5, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("drain_order", 64'(dout_a), 64'(k + 2));
      cycle(1'b0, 16'hFFFF, 1'b1);
    end
    check("drained_valid", 64'(dout_valid_a), 64'd0);

    // Streaming: one word in and one out per cycle, pointers wrap on both depths.
    for (int i = 0; i < 20; i++) begin
      if (i > 0) check("stream_dout", 64'(dout_a), 64'(i - 1));
      cycle(1'b1, W'(i), 1'b1);
    end
    cycle(1'b0, 16'h0000, 1'b1);

    // Head holds while the reader stalls.
    cycle(1'b1, 16'h0011, 1'b0);
    cycle(1'b1, 16'h0022, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check("hold_dout", 64'(dout_a), 64'h0011);
      check("hold_valid", 64'(dout_valid_a), 64'd1);
      cycle(1'b0, W'($urandom), 1'b0);
    end

    // Reset with three entries queued discards them.
    cycle(1'b1, 16'h0033, 1'b0);
    rst_n = 1'b0;
    cycle(1'b1, 16'h0044, 1'b1);
    rst_n = 1'b1;
    check("mrst_valid", 64'(dout_valid_a), 64'd0);
    check("mrst_ready", 64'(din_ready_a), 64'd1);
    check("mrst_dout", 64'(dout_a), 64'd0);
    cycle(1'b0, 16'h0000, 1'b1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    rst_n = 1'b1;
    cycle(1'b0, 16'h0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
